// File: rtl/ov7670_frame_generator_pkg.sv
// Shared definitions for the OV7670 frame generator and the interface_OV7670 receiver:
// state encodings, background pattern codes and default frame timing.
package ov7670_frame_generator_pkg;

    typedef enum logic [2:0] {
        INICIAL  = 3'd0,
        VS_PULSE = 3'd1,
        FRONT    = 3'd2,
        SETUP    = 3'd3,
        ALTO     = 3'd4,
        BAIXO    = 3'd5,
        GAP      = 3'd6,
        FIM      = 3'd7
    } estado_t;

    localparam logic [1:0] PADRAO_ZERO   = 2'd0;
    localparam logic [1:0] PADRAO_COLUNA = 2'd1;
    localparam logic [1:0] PADRAO_XOR    = 2'd2;
    localparam logic [1:0] PADRAO_UNS    = 2'd3;

    localparam int DEF_LINES        = 140;
    localparam int DEF_COLUMNS      = 320;
    localparam int DEF_S_LINE       = 8;
    localparam int DEF_S_COLUMN     = 9;
    localparam int DEF_S_TIMER      = 8;
    localparam int DEF_PCLK_HALF    = 10;
    localparam int DEF_VSYNC_CYCLES = 5;
    localparam int DEF_FRONT_CYCLES = 5;
    localparam int DEF_HREF_SETUP   = 10;
    localparam int DEF_HBLANK       = 5;
    localparam int DEF_MARK_L0      = 31;
    localparam int DEF_MARK_L1      = 78;
    localparam int DEF_MARK_L2      = 125;
    localparam int DEF_MARK_C0      = 65;
    localparam int DEF_MARK_C1      = 139;
    localparam int DEF_MARK_C2      = 233;

endpackage

// File: rtl/hexa7seg.sv
// Hex digit to active-low 7-segment code, segments ordered gfedcba.
module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);
    always_comb begin
        display = 7'b1111111;
        case (hexa)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b0000011;
            4'hC: display = 7'b1000110;
            4'hD: display = 7'b0100001;
            4'hE: display = 7'b0000110;
            default: display = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/ov7670_frame_generator.sv
// OV7670 parallel-output emulator: one VSYNC/HREF/PCLK/D frame per start request,
// background pattern overlaid with a 3x3 grid of marker bytes.
module ov7670_frame_generator
    import ov7670_frame_generator_pkg::*;
#(
    parameter int LINES        = DEF_LINES,
    parameter int COLUMNS      = DEF_COLUMNS,
    parameter int S_LINE       = DEF_S_LINE,
    parameter int S_COLUMN     = DEF_S_COLUMN,
    parameter int S_TIMER      = DEF_S_TIMER,
    parameter int PCLK_HALF    = DEF_PCLK_HALF,
    parameter int VSYNC_CYCLES = DEF_VSYNC_CYCLES,
    parameter int FRONT_CYCLES = DEF_FRONT_CYCLES,
    parameter int HREF_SETUP   = DEF_HREF_SETUP,
    parameter int HBLANK       = DEF_HBLANK,
    parameter int MARK_L0      = DEF_MARK_L0,
    parameter int MARK_L1      = DEF_MARK_L1,
    parameter int MARK_L2      = DEF_MARK_L2,
    parameter int MARK_C0      = DEF_MARK_C0,
    parameter int MARK_C1      = DEF_MARK_C1,
    parameter int MARK_C2      = DEF_MARK_C2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [1:0]  padrao,
    input  logic [71:0] marcadores,
    output logic        VSYNC,
    output logic        HREF,
    output logic        PCLK,
    output logic [7:0]  D,
    output logic        ocupado,
    output logic        pronto,
    output logic [6:0]  db_estado
);
    localparam logic [S_TIMER-1:0]  T_VS     = S_TIMER'(VSYNC_CYCLES - 1);
    localparam logic [S_TIMER-1:0]  T_FRONT  = S_TIMER'(FRONT_CYCLES - 1);
    localparam logic [S_TIMER-1:0]  T_SETUP  = S_TIMER'(HREF_SETUP - 1);
    localparam logic [S_TIMER-1:0]  T_HALF   = S_TIMER'(PCLK_HALF - 1);
    localparam logic [S_TIMER-1:0]  T_GAP    = S_TIMER'(HBLANK - 1);
    localparam logic [S_LINE-1:0]   LINE_LAST = S_LINE'(LINES - 1);
    localparam logic [S_COLUMN-1:0] COL_LAST  = S_COLUMN'(COLUMNS - 1);

    estado_t               estado_q, estado_d;
    logic [S_TIMER-1:0]    timer_q, timer_d;
    logic [S_LINE-1:0]     line_q, line_d;
    logic [S_COLUMN-1:0]   col_q, col_d;
    logic [1:0]            padrao_q, padrao_d;
    logic [71:0]           marc_q, marc_d;
    logic                  vsync_q, vsync_d, href_q, href_d, pclk_q, pclk_d;
    logic                  ocupado_q, ocupado_d, pronto_q, pronto_d;
    logic [7:0]            data_q, data_d;
    logic [6:0]            db_estado_q, db_estado_d;

    function automatic logic [S_LINE-1:0] mark_line(input int r);
        case (r)
            0:       return S_LINE'(MARK_L0);
            1:       return S_LINE'(MARK_L1);
            default: return S_LINE'(MARK_L2);
        endcase
    endfunction

    function automatic logic [S_COLUMN-1:0] mark_col(input int q);
        case (q)
            0:       return S_COLUMN'(MARK_C0);
            1:       return S_COLUMN'(MARK_C1);
            default: return S_COLUMN'(MARK_C2);
        endcase
    endfunction

    // Markers override the background pattern at the grid crossings.
    function automatic logic [7:0] pixel(input logic [S_LINE-1:0] l, input logic [S_COLUMN-1:0] c,
                                         input logic [1:0] p, input logic [71:0] m);
        logic [7:0] b;
        case (p)
            PADRAO_ZERO:   b = 8'h00;
            PADRAO_COLUNA: b = 8'(c);
            PADRAO_XOR:    b = 8'(l) ^ 8'(c);
            default:       b = 8'hFF;
        endcase
        for (int r = 0; r < 3; r++) begin
            for (int q = 0; q < 3; q++) begin
                if (l == mark_line(r) && c == mark_col(q)) b = m[8*(3*r+q) +: 8];
            end
        end
        return b;
    endfunction

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q + 1'b1;
        line_d   = line_q;
        col_d    = col_q;
        padrao_d = padrao_q;
        marc_d   = marc_q;
        case (estado_q)
            INICIAL: begin
                timer_d = '0;
                if (iniciar) begin
                    estado_d = VS_PULSE;
                    padrao_d = padrao;
                    marc_d   = marcadores;
                    line_d   = '0;
                    col_d    = '0;
                end
            end
            VS_PULSE: if (timer_q == T_VS)    begin estado_d = FRONT; timer_d = '0; end
            FRONT:    if (timer_q == T_FRONT) begin estado_d = SETUP; timer_d = '0; end
            SETUP:    if (timer_q == T_SETUP) begin estado_d = ALTO;  timer_d = '0; end
            ALTO: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    if (col_q == COL_LAST) begin
                        estado_d = GAP;
                    end else begin
                        estado_d = BAIXO;
                        col_d    = col_q + 1'b1;
                    end
                end
            end
            BAIXO:    if (timer_q == T_HALF)  begin estado_d = ALTO;  timer_d = '0; end
            GAP: begin
                if (timer_q == T_GAP) begin
                    timer_d = '0;
                    if (line_q == LINE_LAST) begin
                        estado_d = FIM;
                    end else begin
                        estado_d = SETUP;
                        line_d   = line_q + 1'b1;
                        col_d    = '0;
                    end
                end
            end
            FIM: begin
                estado_d = INICIAL;
                timer_d  = '0;
            end
            default: estado_d = INICIAL;
        endcase
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        vsync_d   = (estado_d == INICIAL) || (estado_d == VS_PULSE) || (estado_d == FIM);
        href_d    = (estado_d == SETUP) || (estado_d == ALTO) || (estado_d == BAIXO);
        pclk_d    = (estado_d == ALTO);
        ocupado_d = (estado_d != INICIAL);
        pronto_d  = (estado_d == FIM);
        data_d    = 8'h00;
        case (estado_d)
            SETUP, BAIXO: data_d = pixel(line_d, col_d, padrao_d, marc_d);
            ALTO:         data_d = data_q;
            default:      data_d = 8'h00;
        endcase
    end

    hexa7seg u_hexa7seg (
        .hexa    ({1'b0, estado_d}),
        .display (db_estado_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= INICIAL;
            timer_q     <= '0;
            line_q      <= '0;
            col_q       <= '0;
            padrao_q    <= '0;
            marc_q      <= '0;
            vsync_q     <= 1'b1;
            href_q      <= 1'b0;
            pclk_q      <= 1'b0;
            data_q      <= 8'h00;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
            db_estado_q <= 7'b1000000;
        end else begin
            estado_q    <= estado_d;
            timer_q     <= timer_d;
            line_q      <= line_d;
            col_q       <= col_d;
            padrao_q    <= padrao_d;
            marc_q      <= marc_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            pclk_q      <= pclk_d;
            data_q      <= data_d;
            ocupado_q   <= ocupado_d;
            pronto_q    <= pronto_d;
            db_estado_q <= db_estado_d;
        end
    end

    assign VSYNC     = vsync_q;
    assign HREF      = href_q;
    assign PCLK      = pclk_q;
    assign D         = data_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = db_estado_q;
endmodule

// File: tb/tb_ov7670_frame_generator.sv
// Bench for ov7670_frame_generator on a reduced frame (4 lines x 5 bytes) so whole frames fit the budget.
// Frame length here: 2 + 2 + 4*(3 + 9*2 + 2) + 1 = 97 cycles.
module tb_ov7670_frame_generator;
    localparam int LN = 4;
    localparam int CN = 5;
    localparam int FRAME_LEN = 97;
    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG4 = 7'b0011001;
    localparam logic [6:0] SEG7 = 7'b1111000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iniciar = 1'b0;
    logic [1:0]  padrao = 2'd0;
    logic [71:0] marcadores = '0;
    logic        VSYNC, HREF, PCLK, ocupado, pronto;
    logic [7:0]  D;
    logic [6:0]  db_estado;

    ov7670_frame_generator #(
        .LINES(LN), .COLUMNS(CN), .PCLK_HALF(2), .HREF_SETUP(3), .HBLANK(2),
        .VSYNC_CYCLES(2), .FRONT_CYCLES(2),
        .MARK_L0(0), .MARK_L1(2), .MARK_L2(3), .MARK_C0(0), .MARK_C1(2), .MARK_C2(4)
    ) dut (
        .clock(clk), .reset(rst), .iniciar(iniciar), .padrao(padrao), .marcadores(marcadores),
        .VSYNC(VSYNC), .HREF(HREF), .PCLK(PCLK), .D(D), .ocupado(ocupado), .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Receiver model: samples on the negative clock edge, captures D at each PCLK rise.
    logic [7:0] cap [LN][CN];
    int mon_line = 0, mon_col = 0;
    int n_href = 0, n_rise = 0, n_ocup = 0, n_pronto = 0, n_unstable = 0, n_badline = 0;
    logic pclk_p = 1'b0, href_p = 1'b0, ocup_p = 1'b0;
    logic [7:0] d_p = 8'h00;

    always @(negedge clk) begin
        if (ocupado && !ocup_p) begin
            for (int i = 0; i < LN; i++)
                for (int j = 0; j < CN; j++) cap[i][j] = 8'h5A;
        end
        if (VSYNC) mon_line = 0;
        if (HREF && !href_p) mon_col = 0;
        if (PCLK && !pclk_p) begin
            if (HREF && mon_line < LN && mon_col < CN) cap[mon_line][mon_col] = D;
            mon_col++;
            n_rise++;
        end
        if (PCLK && pclk_p && D != d_p) n_unstable++;
        if (!HREF && href_p) begin
            n_href++;
            if (mon_col != CN) n_badline++;
            mon_line++;
        end
        if (ocupado) n_ocup++;
        if (pronto) n_pronto++;
        pclk_p = PCLK;
        href_p = HREF;
        ocup_p = ocupado;
        d_p    = D;
    end

    typedef struct {
        logic [1:0] pad;
        int         l;
        int         c;
        logic [7:0] exp;
    } vec_t;
    vec_t tab[$];

    int s_href, s_rise, s_ocup, s_pronto, s_unst, s_bad;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic add(input logic [1:0] p, input int l, input int c, input logic [7:0] e);
        vec_t v;
        v.pad = p; v.l = l; v.c = c; v.exp = e;
        tab.push_back(v);
    endtask

    task automatic snapshot();
        s_href = n_href; s_rise = n_rise; s_ocup = n_ocup;
        s_pronto = n_pronto; s_unst = n_unstable; s_bad = n_badline;
    endtask

    task automatic start_frame(input logic [1:0] pad);
        snapshot();
        padrao  = pad;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic wait_pronto(input string name);
        int n;
        n = 0;
        tick();
        while (!pronto && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_pronto_seen"}, int'(pronto), 1);
    endtask

    task automatic finish_frame(input string name);
        wait_pronto(name);
        chk({name, "_db_fim"}, int'(db_estado), int'(SEG7));
        tick();
        chk({name, "_len"},      n_ocup - s_ocup, FRAME_LEN);
        chk({name, "_href"},     n_href - s_href, LN);
        chk({name, "_rises"},    n_rise - s_rise, LN * CN);
        chk({name, "_badline"},  n_badline - s_bad, 0);
        chk({name, "_unstable"}, n_unstable - s_unst, 0);
        chk({name, "_pronto"},   n_pronto - s_pronto, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        for (int k = 0; k < 9; k++) marcadores[8*k +: 8] = 8'hA0 + 8'(k);

        add(2'd1, 1, 0, 8'h00); add(2'd1, 1, 1, 8'h01); add(2'd1, 1, 3, 8'h03);
        add(2'd1, 1, 4, 8'h04); add(2'd1, 0, 1, 8'h01); add(2'd1, 3, 3, 8'h03);
        add(2'd1, 0, 0, 8'hA0); add(2'd1, 2, 2, 8'hA4); add(2'd1, 3, 4, 8'hA8);
        add(2'd2, 1, 1, 8'h00); add(2'd2, 1, 4, 8'h05); add(2'd2, 3, 1, 8'h02);
        add(2'd2, 2, 3, 8'h01); add(2'd2, 3, 3, 8'h00); add(2'd2, 0, 2, 8'hA1);
        add(2'd2, 3, 0, 8'hA6);
        add(2'd0, 1, 2, 8'h00); add(2'd0, 0, 1, 8'h00); add(2'd0, 2, 1, 8'h00);
        add(2'd0, 2, 0, 8'hA3); add(2'd0, 0, 4, 8'hA2);
        add(2'd3, 1, 0, 8'hFF); add(2'd3, 2, 3, 8'hFF); add(2'd3, 0, 3, 8'hFF);
        add(2'd3, 3, 2, 8'hA7); add(2'd3, 2, 4, 8'hA5);

        tick(); tick();
        chk("rst_vsync",   int'(VSYNC), 1);
        chk("rst_href",    int'(HREF), 0);
        chk("rst_pclk",    int'(PCLK), 0);
        chk("rst_d",       int'(D), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_pronto",  int'(pronto), 0);
        chk("rst_db",      int'(db_estado), int'(SEG0));
        rst = 1'b0;
        tick(); tick();

        // Table of bytes: one frame per background pattern.
        foreach (tab[i]) begin
            if (i == 0 || tab[i].pad != tab[i-1].pad) begin
                start_frame(tab[i].pad);
                chk($sformatf("p%0d_db_vs", tab[i].pad), int'(db_estado), int'(SEG1));
                finish_frame($sformatf("frame_p%0d", tab[i].pad));
                tick();
            end
            chk($sformatf("byte_p%0d_l%0d_c%0d", tab[i].pad, tab[i].l, tab[i].c),
                int'(cap[tab[i].l][tab[i].c]), int'(tab[i].exp));
        end

        // Asynchronous reset during a high PCLK phase of line 3.
        start_frame(2'd2);
        n = 0;
        while (!(PCLK && HREF && mon_line == 3) && n < 3000) begin
            tick();
            n++;
        end
        chk("midrst_reached_alto", int'(PCLK && HREF && mon_line == 3), 1);
        chk("midrst_db_alto", int'(db_estado), int'(SEG4));
        rst = 1'b1;
        #1;
        chk("midrst_vsync",   int'(VSYNC), 1);
        chk("midrst_href",    int'(HREF), 0);
        chk("midrst_pclk",    int'(PCLK), 0);
        chk("midrst_d",       int'(D), 0);
        chk("midrst_ocupado", int'(ocupado), 0);
        chk("midrst_db",      int'(db_estado), int'(SEG0));
        tick();
        rst = 1'b0;
        tick();
        start_frame(2'd2);
        finish_frame("after_rst");
        chk("after_rst_byte_l1_c4", int'(cap[1][4]), 8'h05);
        chk("after_rst_byte_l3_c2", int'(cap[3][2]), 8'hA7);
        tick();

        // Second start request and pattern change while busy are ignored.
        start_frame(2'd1);
        repeat (30) tick();
        iniciar = 1'b1;
        padrao  = 2'd3;
        tick();
        iniciar = 1'b0;
        finish_frame("midchg");
        chk("midchg_byte_l1_c4", int'(cap[1][4]), 8'h04);
        chk("midchg_byte_l2_c3", int'(cap[2][3]), 8'h03);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ocupado) cnt++;
        end
        chk("midchg_no_restart", cnt, 0);

        // Start held high: back-to-back frames with a single idle cycle between them.
        snapshot();
        padrao  = 2'd1;
        iniciar = 1'b1;
        wait_pronto("held1");
        tick();
        chk("held_gap_ocupado", int'(ocupado), 0);
        chk("held_gap_vsync",   int'(VSYNC), 1);
        tick();
        chk("held_restart_ocupado", int'(ocupado), 1);
        chk("held_restart_db",      int'(db_estado), int'(SEG1));
        wait_pronto("held2");
        iniciar = 1'b0;
        tick();
        chk("held_pronto_count", n_pronto - s_pronto, 2);
        chk("held_len_two_frames", n_ocup - s_ocup, 2 * FRAME_LEN);
        tick(); tick();
        chk("held_stop_ocupado", int'(ocupado), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
